// File: rtl/snake_sound_sequencer_if.sv
// Event inputs and oscillator-drive outputs of the snake sound-effect sequencer.
// The game logic holds the master side; the sequencer holds the slave side.
interface snake_sound_sequencer_if;
   logic       evt_start;
   logic       evt_eat;
   logic       evt_crash;
   logic       mute;
   logic [8:0] freq;
   logic       play_sound;
   logic       mode;
   logic       busy;
   logic       done;

   modport master (
      output evt_start, evt_eat, evt_crash, mute,
      input  freq, play_sound, mode, busy, done
   );

   modport slave (
      input  evt_start, evt_eat, evt_crash, mute,
      output freq, play_sound, mode, busy, done
   );
endinterface

// File: rtl/snake_sound_sequencer.sv
// Turns one-cycle game-event pulses into short fixed note sequences for the tone
// oscillator; mode is forced OFF between notes so each note restarts its waveform phase.
module snake_sound_sequencer #(
   parameter int TICKS_NOTE = 1_000_000,
   parameter int TICKS_GAP  = 250_000
) (
   input logic                     clk,
   input logic                     nRst,
   snake_sound_sequencer_if.slave  bus
);
   localparam int TMAX = (TICKS_NOTE > TICKS_GAP) ? TICKS_NOTE : TICKS_GAP;
   localparam int CW   = $clog2(TMAX + 1);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_NOTE = 2'd1, ST_GAP = 2'd2} state_t;
   // Encoding doubles as the priority: a larger code preempts a smaller one.
   typedef enum logic [1:0] {SEQ_EAT = 2'd0, SEQ_START = 2'd1, SEQ_CRASH = 2'd2} seq_t;

   function automatic logic [8:0] rom_note(input seq_t s, input logic [1:0] step);
      logic [8:0] f;
      case (s)
         SEQ_START: begin
            case (step)
               2'd0:    f = 9'd262;
               2'd1:    f = 9'd330;
               default: f = 9'd392;
            endcase
         end
         SEQ_EAT: begin
            case (step)
               2'd0:    f = 9'd392;
               default: f = 9'd494;
            endcase
         end
         SEQ_CRASH: begin
            case (step)
               2'd0:    f = 9'd294;
               2'd1:    f = 9'd262;
               2'd2:    f = 9'd220;
               default: f = 9'd196;
            endcase
         end
         default: f = 9'd262;
      endcase
      return f;
   endfunction

   function automatic logic [1:0] last_step(input seq_t s);
      logic [1:0] l;
      case (s)
         SEQ_EAT:   l = 2'd1;
         SEQ_START: l = 2'd2;
         SEQ_CRASH: l = 2'd3;
         default:   l = 2'd0;
      endcase
      return l;
   endfunction

   state_t         state_q;
   seq_t           seq_q;
   logic [1:0]     step_q;
   logic [CW-1:0]  cnt_q;
   logic [8:0]     freq_q;
   logic           mode_q;
   logic           play_q;
   logic           busy_q;
   logic           done_q;

   logic           evt_any_s;
   seq_t           evt_seq_s;
   logic           accept_s;

   // Resolve simultaneous events and decide whether the winner may preempt.
   always_comb begin
      evt_any_s = bus.evt_crash | bus.evt_start | bus.evt_eat;
      if (bus.evt_crash) begin
         evt_seq_s = SEQ_CRASH;
      end else if (bus.evt_start) begin
         evt_seq_s = SEQ_START;
      end else begin
         evt_seq_s = SEQ_EAT;
      end
      if (!evt_any_s) begin
         accept_s = 1'b0;
      end else if (state_q == ST_IDLE) begin
         accept_s = 1'b1;
      end else begin
         accept_s = (evt_seq_s >= seq_q);
      end
   end

   // Sequencer FSM; every output is registered alongside the state.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q <= ST_IDLE;
         seq_q   <= SEQ_EAT;
         step_q  <= 2'd0;
         cnt_q   <= '0;
         freq_q  <= 9'd262;
         mode_q  <= 1'b0;
         play_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept_s) begin
            state_q <= ST_NOTE;
            seq_q   <= evt_seq_s;
            step_q  <= 2'd0;
            cnt_q   <= '0;
            freq_q  <= rom_note(evt_seq_s, 2'd0);
            mode_q  <= 1'b1;
            play_q  <= ~bus.mute;
            busy_q  <= 1'b1;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  mode_q <= 1'b0;
                  play_q <= 1'b0;
                  busy_q <= 1'b0;
               end
               ST_NOTE: begin
                  if (cnt_q == CW'(TICKS_NOTE - 1)) begin
                     state_q <= ST_GAP;
                     cnt_q   <= '0;
                     mode_q  <= 1'b0;
                     play_q  <= 1'b0;
                  end else begin
                     cnt_q  <= cnt_q + CW'(1);
                     play_q <= ~bus.mute;
                  end
               end
               ST_GAP: begin
                  if (cnt_q == CW'(TICKS_GAP - 1)) begin
                     cnt_q <= '0;
                     if (step_q == last_step(seq_q)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= ST_NOTE;
                        step_q  <= step_q + 2'd1;
                        freq_q  <= rom_note(seq_q, step_q + 2'd1);
                        mode_q  <= 1'b1;
                        play_q  <= ~bus.mute;
                     end
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
                  mode_q  <= 1'b0;
                  play_q  <= 1'b0;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.freq       = freq_q;
   assign bus.mode       = mode_q;
   assign bus.play_sound = play_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
endmodule

// File: tb/tb_snake_sound_sequencer.sv
// Bench for snake_sound_sequencer: directed test-plan scenarios plus random events,
// all checked every cycle against a time-since-trigger model of the sequences.
module tb_snake_sound_sequencer;
   localparam int TN = 4;
   localparam int TG = 2;
   localparam int P  = TN + TG;

   logic clk  = 1'b0;
   logic nRst = 1'b0;

   snake_sound_sequencer_if bus ();

   snake_sound_sequencer #(.TICKS_NOTE(TN), .TICKS_GAP(TG)) dut (
      .clk  (clk),
      .nRst (nRst),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Model: an active sequence is "m_t cycles since its first NOTE cycle".
   int notes [3][4] = '{'{392, 494, 0, 0}, '{262, 330, 392, 0}, '{294, 262, 220, 196}};
   int nlen  [3]    = '{2, 3, 4};
   bit         m_active;
   int         m_seq;
   int         m_t;
   logic [8:0] m_last;
   bit         m_done;
   bit         m_mute;
   logic [8:0] e_freq;
   logic       e_mode, e_play, e_busy, e_done;
   int         done_count;

   function automatic void model_eval();
      if (m_active) begin
         int idx;
         int w;
         idx    = m_t / P;
         w      = m_t % P;
         e_mode = (w < TN);
         e_freq = 9'(notes[m_seq][idx]);
         e_play = e_mode & ~m_mute;
         e_busy = 1'b1;
      end else begin
         e_mode = 1'b0;
         e_play = 1'b0;
         e_busy = 1'b0;
         e_freq = m_last;
      end
      e_done = m_done;
   endfunction

   function automatic void model_reset();
      m_active = 1'b0;
      m_seq    = 0;
      m_t      = 0;
      m_last   = 9'd262;
      m_done   = 1'b0;
      m_mute   = 1'b0;
      model_eval();
   endfunction

   function automatic void model_edge(input logic s, input logic e, input logic c, input logic mu);
      int ev;
      ev = -1;
      if (c) ev = 2;
      else if (s) ev = 1;
      else if (e) ev = 0;
      m_done = 1'b0;
      m_mute = mu;
      if (ev >= 0 && (!m_active || ev >= m_seq)) begin
         m_active = 1'b1;
         m_seq    = ev;
         m_t      = 0;
      end else if (m_active) begin
         m_t = m_t + 1;
         if (m_t == nlen[m_seq] * P) begin
            m_active = 1'b0;
            m_done   = 1'b1;
         end
      end
      model_eval();
      if (m_active) m_last = e_freq;
   endfunction

   task automatic compare();
      checks++;
      if ({bus.freq, bus.mode, bus.play_sound, bus.busy, bus.done} !==
          {e_freq, e_mode, e_play, e_busy, e_done}) begin
         failures++;
         $display("FAIL cycle_cmp t=%0t got freq=%0d mode=%b play=%b busy=%b done=%b required freq=%0d mode=%b play=%b busy=%b done=%b",
                  $time, bus.freq, bus.mode, bus.play_sound, bus.busy, bus.done,
                  e_freq, e_mode, e_play, e_busy, e_done);
      end
      if (bus.done === 1'b1) done_count++;
   endtask

   task automatic pin(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("FAIL %s got=%0d required=%0d", name, actual, expected);
      end
   endtask

   // One clock: drive inputs, advance model at the edge, compare at the falling edge.
   task automatic cycle(input logic s, input logic e, input logic c, input logic mu);
      bus.evt_start = s;
      bus.evt_eat   = e;
      bus.evt_crash = c;
      bus.mute      = mu;
      @(posedge clk);
      model_edge(s, e, c, mu);
      @(negedge clk);
      compare();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int busy_cycles;
      int play_cycles;
      int mode_rises;
      logic prev_mode;
      logic mu;

      bus.evt_start = 1'b0;
      bus.evt_eat   = 1'b0;
      bus.evt_crash = 1'b0;
      bus.mute      = 1'b0;
      done_count    = 0;
      model_reset();

      // Reset state, then 20 quiet cycles
      @(negedge clk);
      compare();
      pin("rst_freq", int'(bus.freq), 262);
      @(negedge clk);
      nRst = 1'b1;
      idle(20);
      pin("quiet_freq", int'(bus.freq), 262);
      pin("quiet_busy", int'(bus.busy), 0);

      // EAT alone: literal timeline
      for (int k = 1; k <= 14; k++) begin
         cycle(1'b0, k == 1, 1'b0, 1'b0);
         if (k == 1)  begin pin("eat_c1_freq", int'(e_freq), 392); pin("eat_c1_play", int'(bus.play_sound), 1); end
         if (k == 5)  pin("eat_c5_mode", int'(e_mode), 0);
         if (k == 7)  begin pin("eat_c7_freq", int'(bus.freq), 494); pin("eat_c7_mode", int'(e_mode), 1); end
         if (k == 11) pin("eat_c11_busy", int'(e_busy), 1);
         if (k == 13) begin pin("eat_c13_done", int'(bus.done), 1); pin("eat_c13_busy", int'(e_busy), 0); end
         if (k == 14) pin("eat_c14_done", int'(e_done), 0);
      end

      // EAT preempted by CRASH in note 1's second cycle
      done_count = 0;
      for (int k = 1; k <= 30; k++) begin
         cycle(1'b0, k == 1, k == 3, 1'b0);
         if (k == 3)  pin("preempt_c3_freq", int'(e_freq), 294);
         if (k == 26) pin("preempt_c26_busy", int'(bus.busy), 1);
         if (k == 27) pin("preempt_c27_done", int'(e_done), 1);
      end
      pin("preempt_done_count", done_count, 1);

      // CRASH ignores lower-priority EAT and START during note 2
      busy_cycles = 0;
      for (int k = 1; k <= 28; k++) begin
         cycle(k == 9, k == 8, k == 1, 1'b0);
         if (bus.busy === 1'b1) busy_cycles++;
         if (k == 1)  pin("crash_n1", int'(bus.freq), 294);
         if (k == 7)  pin("crash_n2", int'(bus.freq), 262);
         if (k == 13) pin("crash_n3", int'(e_freq), 220);
         if (k == 19) pin("crash_n4", int'(bus.freq), 196);
      end
      pin("crash_busy_len", busy_cycles, 24);

      // All three at once -> CRASH
      for (int k = 1; k <= 26; k++) begin
         cycle(k == 1, k == 1, k == 1, 1'b0);
         if (k == 1)  pin("simul_freq", int'(bus.freq), 294);
         if (k == 25) pin("simul_done", int'(bus.done), 1);
      end

      // Muted START
      play_cycles = 0;
      mode_rises  = 0;
      prev_mode   = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         cycle(k == 1, 1'b0, 1'b0, 1'b1);
         if (bus.play_sound === 1'b1) play_cycles++;
         if (bus.mode === 1'b1 && prev_mode === 1'b0) mode_rises++;
         prev_mode = bus.mode;
         if (k == 1)  pin("mute_f1", int'(bus.freq), 262);
         if (k == 7)  pin("mute_f2", int'(bus.freq), 330);
         if (k == 13) pin("mute_f3", int'(bus.freq), 392);
         if (k == 19) pin("mute_done", int'(bus.done), 1);
      end
      pin("mute_play_cycles", play_cycles, 0);
      pin("mute_mode_rises", mode_rises, 3);

      // Event in the done cycle is accepted; event on last GAP cycle preempts with no done
      done_count = 0;
      for (int k = 1; k <= 14; k++) begin
         cycle(1'b0, k == 1 || k == 14, 1'b0, 1'b0);
         if (k == 13) pin("donecyc_done", int'(bus.done), 1);
         if (k == 14) pin("donecyc_busy", int'(bus.busy), 1);
      end
      for (int k = 1; k <= 12; k++) cycle(1'b0, 1'b0, k == 12, 1'b0);
      pin("lastgap_done_count", done_count, 1);
      pin("lastgap_freq", int'(bus.freq), 294);
      idle(25);

      // Asynchronous reset in the middle of START note 2
      done_count = 0;
      for (int k = 1; k <= 8; k++) cycle(k == 1, 1'b0, 1'b0, 1'b0);
      pin("rstmid_freq_before", int'(bus.freq), 330);
      #2;
      nRst = 1'b0;
      #1;
      model_reset();
      compare();
      pin("rstmid_freq", int'(bus.freq), 262);
      pin("rstmid_busy", int'(bus.busy), 0);
      @(negedge clk);
      compare();
      nRst = 1'b1;
      idle(20);
      pin("rstmid_no_done", done_count, 0);

      // Random events and mute
      mu = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = $urandom_range(0, 15);
         if ($urandom_range(0, 31) == 0) mu = ~mu;
         cycle(r == 0 || r == 3, r == 1 || r == 3, r == 2, mu);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/snake_sound_sequencer.md
# snake_sound_sequencer

Sound-effect sequencer that turns one-cycle game-event pulses (game start, apple eaten, crash) into short fixed note sequences. It sits directly upstream of the tone oscillator and drives that oscillator's frequency, play-enable and ON/OFF mode inputs. The oscillator's count resets whenever its mode is OFF, so this block forces mode OFF between notes to restart the waveform phase cleanly on every note.

## Interface
- TICKS_NOTE, default 1_000_000: clk cycles each note sounds (0.1 s at 10 MHz); must be ≥ 1.
- TICKS_GAP, default 250_000: clk cycles of silence after every note; must be ≥ 1.
- clk  input  1  system clock (10 MHz nominal).
- nRst  input  1  reset, asynchronous, active-low.
- evt_start  input  1  one-cycle pulse: new game started.
- evt_eat  input  1  one-cycle pulse: snake ate an apple.
- evt_crash  input  1  one-cycle pulse: snake collided or game over.
- mute  input  1  level; when high, play_sound is forced low.
- freq  output  9  note frequency in Hz, to the oscillator; never 0.
- play_sound  output  1  oscillator count enable.
- mode  output  1  oscillator mode; 1 = ON, 0 = OFF.
- busy  output  1  high while a sequence is in progress.
- done  output  1  one-cycle pulse when a sequence completes normally.

## Operation
- Fixed sequences are held in an internal ROM, note values in Hz.
  - START, priority 1: 262, 330, 392.
  - EAT, priority 0: 392, 494.
  - CRASH, priority 2: 294, 262, 220, 196.
- FSM states: IDLE, NOTE, GAP.
  - IDLE to NOTE: on an accepted event. The step index is set to 0 and the sequence/priority is latched.
  - NOTE to GAP: after TICKS_NOTE cycles.
  - GAP to NOTE: after TICKS_GAP cycles, if more notes remain; the step index increments.
  - GAP to IDLE: after the last note's gap. done pulses.
- Event acceptance:
  - Simultaneous events are resolved as crash > start > eat.
  - In IDLE, any event is accepted.
  - In NOTE or GAP, an event is accepted only if its priority is ≥ the latched priority.
  - An accepted event restarts from step 0 of the new sequence in NOTE, with the tick counter cleared. Equal priority means a retrigger, which restarts the same sequence.
  - A lower-priority event is dropped, not queued.
- A preempted sequence produces no done pulse.
- Outputs are all registered:
  - NOTE: mode=1, play_sound=~mute, freq=ROM note.
  - GAP: mode=0, play_sound=0, freq holds the current note.
  - IDLE: mode=0, play_sound=0, freq holds the last note played.
- mute affects only play_sound. State, timing, freq, busy and done are unchanged.
- busy = (state != IDLE).
- Tick counter width is $clog2(max(TICKS_NOTE, TICKS_GAP)+1) and it saturates never. It is reloaded to 0 on every state change.

## Timing
- Reset values: freq=9'd262, mode=0, play_sound=0, busy=0, done=0, state IDLE, step 0, counter 0.
- nRst low mid-sequence returns everything to the reset values immediately, asynchronously. The sequence is abandoned with no done pulse.
- Latency: event sampled high at edge k. The NOTE outputs (mode=1, play_sound, freq) are valid in the cycle after edge k, and so is busy=1.
- Each NOTE phase lasts exactly TICKS_NOTE cycles; each GAP phase lasts exactly TICKS_GAP cycles.
- A sequence of n notes keeps busy high for n×(TICKS_NOTE+TICKS_GAP) cycles.
- done is high for exactly one cycle: the first IDLE cycle, which is also the first cycle with busy=0.
- An event arriving in that same done cycle is accepted normally. done still pulses, and busy rises on the next cycle.
- Preemption on the last cycle of a GAP: the new event wins, and there is no done pulse.

## Test plan
All scenarios use TICKS_NOTE=4, TICKS_GAP=2.
- Reset release, no events → freq=262, mode=0, play_sound=0, busy=0, done=0 held for 20 cycles.
- evt_eat pulse at edge 0 → cycles 1–4: mode=1, play_sound=1, freq=392. Cycles 5–6: mode=0, play_sound=0. Cycles 7–10: freq=494, mode=1. Cycles 11–12: gap. Cycle 13: busy=0, done=1. Cycle 14: done=0.
- evt_eat, then evt_crash in the 2nd cycle of note 1 → the next cycle shows freq=294, mode=1, counter restarted. Crash runs 24 cycles. There is exactly one done, at the end of crash.
- evt_crash, then evt_eat and evt_start during crash note 2 → both are ignored. The freq sequence is 294, 262, 220, 196; busy lasts 24 cycles.
- evt_eat, evt_start and evt_crash in the same cycle → CRASH sequence plays.
- mute=1 throughout evt_start → play_sound stays 0 and mode toggles as normal. freq goes 262, 330, 392; done occurs at cycle 19. Also: nRst pulse in the middle of note 2 → all outputs return to reset values, with no done.
